// File: rtl/spi_keys_rx_if.sv
// ---------------------------------------------------------------------------
// spi_keys_rx_if
//   Bundle of the SPI receive link signals and the recovered key-state outputs.
//
//   spi_clk_i     SPI SCK (mode 0), asynchronous to the core clock
//   spi_mosi_i    SPI data, MSB first
//   keys_o        last committed key state (NUM_KEYS bits)
//   keys_valid_o  one-cycle pulse when keys_o updates
//   frame_err_o   one-cycle pulse when a partial frame is discarded
//   frame_cnt_o   count of committed frames, wraps 255 -> 0
//
//   master: the side driving SCK/MOSI and observing the key outputs
//   slave : the receiver (spi_keys_rx)
// ---------------------------------------------------------------------------
interface spi_keys_rx_if #(
    parameter int NUM_KEYS = 61
);
    logic                spi_clk_i;
    logic                spi_mosi_i;
    logic [NUM_KEYS-1:0] keys_o;
    logic                keys_valid_o;
    logic                frame_err_o;
    logic [7:0]          frame_cnt_o;

    modport master (
        output spi_clk_i,
        output spi_mosi_i,
        input  keys_o,
        input  keys_valid_o,
        input  frame_err_o,
        input  frame_cnt_o
    );

    modport slave (
        input  spi_clk_i,
        input  spi_mosi_i,
        output keys_o,
        output keys_valid_o,
        output frame_err_o,
        output frame_cnt_o
    );
endinterface

// File: rtl/spi_keys_rx.sv
// ---------------------------------------------------------------------------
// spi_keys_rx
//   Receive-side SPI slave for the key-state link. Oversamples SCK/MOSI on
//   the core clock, reassembles frames of ceil(NUM_KEYS/8) bytes (MSB first
//   within each byte, byte 0 first) and publishes them as a parallel key
//   vector. Frame alignment is by byte counting; a partial frame is dropped
//   when SCK stays idle for IDLE_TIMEOUT core cycles.
//
//   clk_g_int_buf  core clock, at least 4x SCK
//   rstn_g_i       asynchronous active-low reset
//   bus            spi_keys_rx_if.slave (SCK/MOSI in, key state out)
//
//   Latency: the last SCK rise of a frame captured by synchroniser stage 1
//   at edge E gives keys_o/frame_cnt_o updated and keys_valid_o high at E+4.
// ---------------------------------------------------------------------------
module spi_keys_rx #(
    parameter int NUM_KEYS     = 61,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic          clk_g_int_buf,
    input  logic          rstn_g_i,
    spi_keys_rx_if.slave  bus
);
    localparam int GROUPS = (NUM_KEYS + 7) / 8;
    localparam int BC_W   = $clog2(GROUPS) + 1;
    localparam int KI_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(GROUPS - 1);
    // Timeout fires on the edge where idle_cnt becomes IDLE_TIMEOUT.
    localparam logic [15:0]     TO_PRE    = 16'(IDLE_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECV   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // Synchronisers: [0] = stage 1, [1] = stage 2, [2] = edge-detect history.
    logic [2:0] sck_s;
    logic [1:0] mosi_s;
    logic       sck_rise_q;
    logic       mosi_q;

    logic [1:0]          state;
    logic [2:0]          bit_cnt;
    logic [BC_W-1:0]     byte_cnt;
    logic [6:0]          shift_q;   // earlier bits of the byte in progress
    logic [NUM_KEYS-1:0] shadow;    // padding bits are never stored
    logic [15:0]         idle_cnt;
    logic [7:0]          byte_in;

    assign byte_in = {shift_q, mosi_q};

    // NOTE: every sequential assignment is non-blocking so all flops sample
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_g_int_buf or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            sck_s      <= '0;
            mosi_s     <= '0;
            sck_rise_q <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            sck_s      <= {sck_s[1:0], bus.spi_clk_i};
            mosi_s     <= {mosi_s[0], bus.spi_mosi_i};
            // Strobe and data registered together so they stay aligned.
            sck_rise_q <= sck_s[1] & ~sck_s[2];
            mosi_q     <= mosi_s[1];
        end
    end

    always_ff @(posedge clk_g_int_buf or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            state            <= ST_IDLE;
            bit_cnt          <= '0;
            byte_cnt         <= '0;
            shift_q          <= '0;
            // NOTE: shadow is a register bank, not a RAM, and it is reset to
            // all ones so a truncated first frame can never expose garbage.
            shadow           <= '1;
            idle_cnt         <= '0;
            bus.keys_o       <= '1;
            bus.keys_valid_o <= 1'b0;
            bus.frame_err_o  <= 1'b0;
            bus.frame_cnt_o  <= '0;
        end else begin
            bus.keys_valid_o <= 1'b0;
            bus.frame_err_o  <= 1'b0;

            if (sck_rise_q) begin
                idle_cnt <= '0;
            end else if (idle_cnt != 16'hFFFF) begin
                idle_cnt <= idle_cnt + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    if (sck_rise_q) begin
                        shift_q <= byte_in[6:0];
                        bit_cnt <= 3'd1;
                        state   <= ST_RECV;
                    end
                end

                ST_RECV: begin
                    if (sck_rise_q) begin
                        shift_q <= byte_in[6:0];
                        bit_cnt <= bit_cnt + 3'd1;   // wraps to 0 after bit 7
                        if (bit_cnt == 3'd7) begin
                            for (int b = 0; b < 8; b++) begin
                                if (int'(byte_cnt) * 8 + b < NUM_KEYS) begin
                                    shadow[KI_W'(int'(byte_cnt) * 8 + b)] <= byte_in[b];
                                end
                            end
                            byte_cnt <= byte_cnt + 1'b1;
                            if (byte_cnt == LAST_BYTE) begin
                                state <= ST_COMMIT;
                            end
                        end
                    end else if (idle_cnt == TO_PRE) begin
                        bit_cnt         <= '0;
                        byte_cnt        <= '0;
                        bus.frame_err_o <= 1'b1;
                        state           <= ST_IDLE;
                    end
                end

                ST_COMMIT: begin
                    // An SCK rise here is impossible at >=4x oversampling and
                    // is dropped if it ever happens.
                    bus.keys_o       <= shadow;
                    bus.keys_valid_o <= 1'b1;
                    bus.frame_cnt_o  <= bus.frame_cnt_o + 8'd1;
                    byte_cnt         <= '0;
                    state            <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_keys_rx.sv
// ---------------------------------------------------------------------------
// tb_spi_keys_rx
//   Directed bench for spi_keys_rx. SCK runs at clk/4. A byte/frame level
//   model predicts key vector, valid/error pulses and frame count, and one
//   compare process checks them every cycle; literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_spi_keys_rx;
    localparam int NK = 61;
    localparam int TO = 255;
    localparam int GR = (NK + 7) / 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    spi_keys_rx_if #(.NUM_KEYS(NK)) bus ();

    spi_keys_rx #(.NUM_KEYS(NK), .IDLE_TIMEOUT(TO)) dut (
        .clk_g_int_buf (clk),
        .rstn_g_i      (rstn),
        .bus           (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------- model
    typedef struct {
        int          at;
        logic [NK-1:0] keys;
    } ev_t;

    ev_t           ev[$];
    logic [7:0]    m_frame[$];
    logic [7:0]    m_cur    = '0;
    int            m_nbits  = 0;
    logic [NK-1:0] m_keys   = '1;
    int            m_cnt    = 0;
    int            err_at   = -1;
    int            last_e   = 0;
    int            valid_seen = 0;
    int            err_seen   = 0;
    int            last_valid_cyc = 0;
    int            last_err_cyc   = 0;

    function automatic logic [NK-1:0] frame_to_keys();
        logic [NK-1:0] k = '0;
        for (int g = 0; g < GR; g++)
            for (int b = 0; b < 8; b++)
                if (8 * g + b < NK) k[8 * g + b] = m_frame[g][b];
        return k;
    endfunction

    // Called when the bench raises SCK; e is the cycle stage 1 captures it.
    function automatic void model_rise(input bit b, input int e);
        m_cur = {m_cur[6:0], b};
        m_nbits++;
        last_e = e;
        if (m_nbits == 8) begin
            m_frame.push_back(m_cur);
            m_nbits = 0;
        end
        if (m_frame.size() == GR) begin
            ev.push_back('{at: e + 4, keys: frame_to_keys()});
            m_frame.delete();
            err_at = -1;
        end else begin
            err_at = e + 3 + TO;
        end
    endfunction

    function automatic void model_reset();
        ev.delete();
        m_frame.delete();
        m_nbits = 0;
        m_keys  = '1;
        m_cnt   = 0;
        err_at  = -1;
    endfunction

    // ------------------------------------------------------------ compare
    always @(posedge clk) begin
        bit exp_valid;
        bit exp_err;
        #1;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (ev.size() > 0 && ev[0].at == cyc) begin
            exp_valid = 1'b1;
            m_keys    = ev[0].keys;
            m_cnt     = (m_cnt + 1) % 256;
            void'(ev.pop_front());
        end
        if (err_at == cyc) begin
            exp_err = 1'b1;
            m_frame.delete();
            m_nbits = 0;
            err_at  = -1;
        end
        if (bus.keys_valid_o === 1'b1) begin
            valid_seen++;
            last_valid_cyc = cyc;
        end
        if (bus.frame_err_o === 1'b1) begin
            err_seen++;
            last_err_cyc = cyc;
        end
        check("keys",  64'(bus.keys_o),       64'(m_keys));
        check("valid", 64'(bus.keys_valid_o), 64'(exp_valid));
        check("err",   64'(bus.frame_err_o),  64'(exp_err));
        check("cnt",   64'(bus.frame_cnt_o),  64'(m_cnt));
    end

    // ------------------------------------------------------------ drivers
    task automatic sck_bit(input bit b);
        @(negedge clk);
        bus.spi_clk_i  = 1'b0;
        bus.spi_mosi_i = b;
        @(negedge clk);
        @(negedge clk);
        bus.spi_clk_i = 1'b1;
        model_rise(b, cyc + 1);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) sck_bit(v[i]);
    endtask

    task automatic send_frame(input logic [63:0] bytes_lsb_first);
        for (int g = 0; g < GR; g++) send_byte(bytes_lsb_first[8 * g +: 8]);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.spi_clk_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        bus.spi_clk_i = 1'b0;
        rstn = 1'b0;
        model_reset();
        repeat (n) @(negedge clk);
        rstn = 1'b1;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int v0;
        int e0;
        bus.spi_clk_i  = 1'b0;
        bus.spi_mosi_i = 1'b0;

        // Reset values.
        do_reset(3);
        check("rst_keys",  64'(bus.keys_o),       64'h1FFF_FFFF_FFFF_FFFF);
        check("rst_valid", 64'(bus.keys_valid_o), 64'd0);
        check("rst_cnt",   64'(bus.frame_cnt_o),  64'd0);

        // Single frame FE FF FF FF FF FF FF 1F (byte 0 first).
        v0 = valid_seen;
        send_frame(64'h1FFF_FFFF_FFFF_FFFE);
        idle(10);
        check("f1_keys",    64'(bus.keys_o),      64'h1FFF_FFFF_FFFF_FFFE);
        check("f1_cnt",     64'(bus.frame_cnt_o), 64'd1);
        check("f1_pulses",  64'(valid_seen - v0), 64'd1);
        check("f1_latency", 64'(last_valid_cyc - last_e), 64'd4);

        // Same frame with padding bits set.
        send_frame(64'hFFFF_FFFF_FFFF_FFFE);
        idle(10);
        check("pad_keys", 64'(bus.keys_o),      64'h1FFF_FFFF_FFFF_FFFE);
        check("pad_cnt",  64'(bus.frame_cnt_o), 64'd2);
        check("pad_err",  64'(err_seen),        64'd0);

        // Truncated frame, SCK idle, then a full zero frame.
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        e0 = last_e;
        idle(300);
        check("to_pulses", 64'(err_seen), 64'd1);
        check("to_delay",  64'(last_err_cyc - e0), 64'd258);
        check("to_keys",   64'(bus.keys_o), 64'h1FFF_FFFF_FFFF_FFFE);
        check("to_cnt",    64'(bus.frame_cnt_o), 64'd2);
        send_frame(64'h0);
        idle(10);
        check("zero_keys", 64'(bus.keys_o), 64'd0);

        // Back-to-back frames, then wrap of the frame counter.
        do_reset(3);
        v0 = valid_seen;
        send_frame(64'h0101_0101_0101_0101);
        send_frame(64'h0202_0202_0202_0202);
        idle(10);
        check("b2b_pulses", 64'(valid_seen - v0), 64'd2);
        check("b2b_bits",   64'(bus.keys_o[1:0]), 64'd2);
        check("b2b_cnt",    64'(bus.frame_cnt_o), 64'd2);
        for (int f = 0; f < 255; f++)
            send_frame({8{8'(f)}});
        idle(10);
        check("wrap_cnt",  64'(bus.frame_cnt_o), 64'd1);
        check("wrap_keys", 64'(bus.keys_o), 64'h1EFE_FEFE_FEFE_FEFE);

        // Reset in the middle of a frame.
        v0 = err_seen;
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) sck_bit(1'b1);
        idle(2);
        do_reset(3);
        idle(5);
        send_frame(64'h5555_5555_5555_5555);
        idle(300);
        check("mid_keys", 64'(bus.keys_o),      64'h1555_5555_5555_5555);
        check("mid_cnt",  64'(bus.frame_cnt_o), 64'd1);
        check("mid_err",  64'(err_seen - v0),   64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
